// File: rtl/ysyx_220053_trap_seq_if.sv
// CSR trap-write strobe plus fetch redirect handshake between the trap
// sequencer (master) and the CSR file / fetch stage (slave).
interface ysyx_220053_trap_seq_if #(
    parameter int XLEN = 64
);
    logic            trap_we;
    logic [XLEN-1:0] trap_epc;
    logic [XLEN-1:0] trap_cause;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output trap_we, trap_epc, trap_cause,
        output redirect_valid, redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  trap_we, trap_epc, trap_cause,
        input  redirect_valid, redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/ysyx_220053_trap_seq.sv
// Machine-mode trap sequencer: ecall/ebreak/mret -> CSR trap write -> PC redirect.
// Optional timer interrupt entry when YSYX_220053_TRAP_TIMER_IRQ_EN is defined.
module ysyx_220053_trap_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ecall_req,
    input  logic                 ebreak_req,
    input  logic                 mret_req,
    input  logic [XLEN-1:0]      ex_pc,
    input  logic [XLEN-1:0]      csr_mtvec,
    input  logic [XLEN-1:0]      csr_mepc,
    input  logic                 mstatus_we,
    input  logic [XLEN-1:0]      mstatus_wdata,
    input  logic                 timer_irq,
    output logic                 busy,
    output logic [XLEN-1:0]      mstatus_rd,
    output logic [CNT_W-1:0]     trap_count,
    ysyx_220053_trap_seq_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2,
        RET    = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
    localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_MTI    = {1'b1, (XLEN-1)'(7)};

    state_t          state, state_n;
    logic [XLEN-1:0] epc_q, cause_q, cause_n;
    logic            mie, mpie;
    logic            take_trap, take_mret;
    logic [CNT_W-1:0] cnt;

    // Only the MIE/MPIE bits and the aligned part of mtvec are consumed.
    logic unused_bits;
`ifdef YSYX_220053_TRAP_TIMER_IRQ_EN
    logic irq_pend;
    assign irq_pend    = timer_irq & mie;
    assign unused_bits = ^{mstatus_wdata[XLEN-1:8], mstatus_wdata[6:4],
                           mstatus_wdata[2:0], csr_mtvec[1:0]};
`else
    assign unused_bits = ^{mstatus_wdata[XLEN-1:8], mstatus_wdata[6:4],
                           mstatus_wdata[2:0], csr_mtvec[1:0], timer_irq};
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n            = state;
        take_trap          = 1'b0;
        take_mret          = 1'b0;
        cause_n            = '0;
        busy               = 1'b0;
        bus.trap_we        = 1'b0;
        bus.trap_epc       = '0;
        bus.trap_cause     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        unique case (state)
            IDLE: begin
                if (ecall_req) begin
                    take_trap = 1'b1;
                    cause_n   = CAUSE_ECALL;
                end else if (ebreak_req) begin
                    take_trap = 1'b1;
                    cause_n   = CAUSE_EBREAK;
                end else if (mret_req) begin
                    take_mret = 1'b1;
`ifdef YSYX_220053_TRAP_TIMER_IRQ_EN
                end else if (irq_pend) begin
                    take_trap = 1'b1;
                    cause_n   = CAUSE_MTI;
`endif
                end
                if (take_trap)      state_n = SAVE;
                else if (take_mret) state_n = RET;
            end
            SAVE: begin
                busy           = 1'b1;
                bus.trap_we    = 1'b1;
                bus.trap_epc   = epc_q;
                bus.trap_cause = cause_q;
                state_n        = VECTOR;
            end
            VECTOR: begin
                busy               = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = {csr_mtvec[XLEN-1:2], 2'b00};
                if (bus.redirect_ready) state_n = IDLE;
            end
            RET: begin
                busy               = 1'b1;
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = csr_mepc;
                if (bus.redirect_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Trap entry (SAVE) and mret both outrank a same-cycle software mstatus write.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q   <= '0;
            cause_q <= '0;
            mie     <= 1'b0;
            mpie    <= 1'b0;
            cnt     <= '0;
        end else begin
            if (take_trap) begin
                epc_q   <= ex_pc;
                cause_q <= cause_n;
            end
            if (state == SAVE) begin
                mpie <= mie;
                mie  <= 1'b0;
                if (cnt != '1) cnt <= cnt + 1'b1;
            end else if (take_mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (mstatus_we) begin
                mie  <= mstatus_wdata[3];
                mpie <= mstatus_wdata[7];
            end
        end
    end

    always_comb begin
        mstatus_rd    = '0;
        mstatus_rd[3] = mie;
        mstatus_rd[7] = mpie;
    end

    assign trap_count = cnt;

endmodule
